// File: rtl/sdram_arb_pkg.sv
// Shared constants and types for the SDRAM command-port arbiter.
// Port indices, port count and arbiter FSM state encoding.
package sdram_arb_pkg;

    localparam int NPORT  = 3;
    localparam int P_DISP = 0;
    localparam int P_CAM  = 1;
    localparam int P_SD   = 2;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_BUSY
    } state_e;

endpackage

// File: rtl/sdram_arb_rr.sv
// Two-way round-robin picker for the camera and SD-card ports.
// ptr_i=0 prefers req_i[0], ptr_i=1 prefers req_i[1]; output is one-hot.
module sdram_arb_rr (
    input  logic [1:0] req_i,
    input  logic       ptr_i,
    output logic [1:0] pick_o
);

    // preferred side first, otherwise the other side
    always_comb begin
        pick_o = 2'b00;
        if (ptr_i) begin
            if (req_i[1])      pick_o = 2'b10;
            else if (req_i[0]) pick_o = 2'b01;
        end else begin
            if (req_i[0])      pick_o = 2'b01;
            else if (req_i[1]) pick_o = 2'b10;
        end
    end

endmodule

// File: rtl/sdram_port_arbiter.sv
// Three-port SDRAM command arbiter: display port has priority with a
// starvation limit, camera/SD round-robin. Optional macro ARB_TIMEOUT_EN.
module sdram_port_arbiter
    import sdram_arb_pkg::*;
#(
    parameter int ADDR_W     = 22,
    parameter int LEN_W      = 9,
    parameter int STARVE_MAX = 4
`ifdef ARB_TIMEOUT_EN
    ,
    parameter int TIMEOUT    = 4096
`endif
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NPORT-1:0]        req,
    input  logic [NPORT-1:0]        wr,
    input  logic [NPORT*ADDR_W-1:0] addr,
    input  logic [NPORT*LEN_W-1:0]  len,
    input  logic [NPORT*16-1:0]     wdata,
    output logic [NPORT-1:0]        gnt,
    output logic [NPORT-1:0]        done,
    output logic [NPORT-1:0]        wdata_req,
    output logic [NPORT-1:0]        rdata_vld,
    output logic                    cmd_valid,
    input  logic                    cmd_ready,
    output logic                    cmd_wr,
    output logic [ADDR_W-1:0]       cmd_addr,
    output logic [LEN_W-1:0]        cmd_len,
    input  logic                    ctl_wreq,
    output logic [15:0]             ctl_wdata,
    input  logic                    ctl_rvld,
    input  logic                    cmd_done,
    output logic                    err
);

    localparam int SW = $clog2(STARVE_MAX + 1);
    localparam logic [SW-1:0] SMAX = SW'(STARVE_MAX);

    state_e              state_q, state_d;
    logic [NPORT-1:0]    gnt_q, gnt_d;
    logic [NPORT-1:0]    done_q, done_d;
    logic                wr_q, wr_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [LEN_W-1:0]    len_q, len_d;
    logic [SW-1:0]       starve_q, starve_d;
    logic                rr_q, rr_d;

    logic [1:0]          rr_pick;
    logic                p0_ok;
    logic                others;
    logic [NPORT-1:0]    win;
    logic                win_wr;
    logic [ADDR_W-1:0]   win_addr;
    logic [LEN_W-1:0]    win_len;
    logic                busy;
    logic                fin;
    logic                tmo_hit;

    sdram_arb_rr u_rr (
        .req_i  (req[P_SD:P_CAM]),
        .ptr_i  (rr_q),
        .pick_o (rr_pick)
    );

    // winner selection and the winner's command fields
    always_comb begin
        others = req[P_SD:P_CAM] != 2'b00;
        p0_ok  = req[P_DISP] && !(starve_q == SMAX && others);
        win    = '0;
        if (p0_ok) win[P_DISP]     = 1'b1;
        else       win[P_SD:P_CAM] = rr_pick;
        win_wr   = 1'b0;
        win_addr = '0;
        win_len  = '0;
        for (int i = 0; i < NPORT; i++) begin
            if (win[i]) begin
                win_wr   = wr[i];
                win_addr = addr[i*ADDR_W +: ADDR_W];
                win_len  = len[i*LEN_W +: LEN_W];
            end
        end
    end

    // next state, grant, command fields, fairness bookkeeping
    always_comb begin
        state_d  = state_q;
        gnt_d    = gnt_q;
        done_d   = '0;
        wr_d     = wr_q;
        addr_d   = addr_q;
        len_d    = len_q;
        starve_d = starve_q;
        rr_d     = rr_q;
        case (state_q)
            S_IDLE: begin
                // gnt still high here only for a zero-length completion
                if (gnt_q != '0) begin
                    gnt_d = '0;
                end else if (req != '0) begin
                    gnt_d  = win;
                    wr_d   = win_wr;
                    addr_d = win_addr;
                    len_d  = win_len;
                    if (win[P_DISP]) begin
                        if (others && starve_q != SMAX)
                            starve_d = starve_q + 1'b1;
                    end else begin
                        starve_d = '0;
                        rr_d     = win[P_CAM];
                    end
                    if (win_len == '0) done_d  = win;
                    else               state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (cmd_ready) state_d = S_BUSY;
            end
            S_BUSY: begin
                if (fin) begin
                    gnt_d   = '0;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // state and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            gnt_q    <= '0;
            done_q   <= '0;
            wr_q     <= 1'b0;
            addr_q   <= '0;
            len_q    <= '0;
            starve_q <= '0;
            rr_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            gnt_q    <= gnt_d;
            done_q   <= done_d;
            wr_q     <= wr_d;
            addr_q   <= addr_d;
            len_q    <= len_d;
            starve_q <= starve_d;
            rr_q     <= rr_d;
        end
    end

`ifdef ARB_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0] TLAST = TW'(TIMEOUT - 1);

    logic [TW-1:0] tmr_q, tmr_d;
    logic          err_q, err_d;

    assign tmo_hit = tmr_q == TLAST;

    // BUSY cycle counter and sticky timeout flag
    always_comb begin
        tmr_d = busy ? tmr_q + 1'b1 : '0;
        err_d = err_q | (busy & tmo_hit & ~cmd_done);
    end

    // timeout registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tmr_q <= '0;
            err_q <= 1'b0;
        end else begin
            tmr_q <= tmr_d;
            err_q <= err_d;
        end
    end

    assign err = err_q;
`else
    assign tmo_hit = 1'b0;
    assign err     = 1'b0;
`endif

    assign busy      = state_q == S_BUSY;
    assign fin       = busy && (cmd_done || tmo_hit);
    assign gnt       = gnt_q;
    assign done      = done_q | (gnt_q & {NPORT{fin}});
    assign wdata_req = gnt_q & {NPORT{busy & ctl_wreq}};
    assign rdata_vld = gnt_q & {NPORT{busy & ctl_rvld}};
    assign cmd_valid = state_q == S_ISSUE;
    assign cmd_wr    = wr_q;
    assign cmd_addr  = addr_q;
    assign cmd_len   = len_q;

    // write data from the granted port while streaming
    always_comb begin
        ctl_wdata = '0;
        for (int i = 0; i < NPORT; i++) begin
            if (busy && gnt_q[i]) ctl_wdata = wdata[i*16 +: 16];
        end
    end

endmodule
